// File: rtl/mem_access_stage_pkg.sv
// mips32_defs: shared aluop load/store codes, exception codes, mem-stage FSM encoding and access-shape helpers
package mips32_defs;
  localparam logic [7:0] OP_LB  = 8'h90;
  localparam logic [7:0] OP_LBU = 8'h91;
  localparam logic [7:0] OP_LH  = 8'h92;
  localparam logic [7:0] OP_LHU = 8'h93;
  localparam logic [7:0] OP_LW  = 8'h94;
  localparam logic [7:0] OP_SB  = 8'h98;
  localparam logic [7:0] OP_SH  = 8'h99;
  localparam logic [7:0] OP_SW  = 8'h9A;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE, ST_DRAIN} mem_state_e;
  function automatic logic is_load(input logic [7:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction
  function automatic logic is_store(input logic [7:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction
  function automatic logic is_half(input logic [7:0] op);
    return op inside {OP_LH, OP_LHU, OP_SH};
  endfunction
  function automatic logic is_word(input logic [7:0] op);
    return op inside {OP_LW, OP_SW};
  endfunction
  function automatic logic [3:0] access_be(input logic [7:0] op, input logic [1:0] a);
    return is_word(op) ? 4'hF : is_half(op) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
  endfunction
  function automatic logic [31:0] lane_data(input logic [7:0] op, input logic [31:0] din);
    return is_word(op) ? din : is_half(op) ? {2{din[15:0]}} : {4{din[7:0]}};
  endfunction
endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: picks the addressed byte/halfword lane of rdata and sign/zero extends it per load op (op, addr -> data)
module load_align
  import mips32_defs::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;
  assign b    = rdata[{addr, 3'b000} +: 8];
  assign h    = addr[1] ? rdata[31:16] : rdata[15:0];
  assign sx   = op == OP_LB || op == OP_LH;
  assign data = is_word(op) ? rdata : is_half(op) ? {{16{sx & h[15]}}, h} : {{24{sx & b[7]}}, b};
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage bus FSM; EXE/MEM inputs (mem_*), flush -> dm_* bus request, stall_req, wb_* result
module mem_access_stage
  import mips32_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mem_aluop,
  input  logic [4:0]  mem_wa,
  input  logic        mem_wreg,
  input  logic        mem_mreg,
  input  logic [31:0] mem_wd,
  input  logic [31:0] mem_din,
  input  logic [4:0]  mem_exccode,
  input  logic        flush,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_req,
  output logic [4:0]  wb_wa,
  output logic [31:0] wb_wd,
  output logic        wb_wreg,
  output logic [4:0]  wb_exccode
);
  mem_state_e  state;
  logic        ld, st, mem, misalign, access, done, mreg_unused;
  logic [31:0] rdata_q, ld_data;
  assign ld          = is_load(mem_aluop);
  assign st          = is_store(mem_aluop);
  assign mem         = ld | st;
  assign misalign    = (is_half(mem_aluop) & mem_wd[0]) | (is_word(mem_aluop) & |mem_wd[1:0]);
  assign access      = mem && mem_exccode == EXC_NONE && !misalign;
  assign done        = state == ST_DONE;
  assign mreg_unused = mem_mreg;
  load_align u_align (.op(mem_aluop), .addr(mem_wd[1:0]), .rdata(rdata_q), .data(ld_data));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= '0;
      dm_wdata <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (access && !flush) begin
          dm_req   <= 1'b1;
          dm_we    <= st;
          dm_addr  <= {mem_wd[31:2], 2'b00};
          dm_be    <= access_be(mem_aluop, mem_wd[1:0]);
          dm_wdata <= lane_data(mem_aluop, mem_din);
          state    <= ST_BUSY;
        end
        ST_BUSY: if (dm_ack) begin
          dm_req  <= 1'b0;
          rdata_q <= dm_rdata;
          state   <= flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state <= ST_DRAIN;
        end
        ST_DONE: state <= ST_IDLE;
        ST_DRAIN: if (dm_ack) begin
          dm_req <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign stall_req  = rst_n && !flush && ((state == ST_IDLE && access) || state == ST_BUSY);
  assign wb_wa      = mem_wa;
  assign wb_wd      = done && ld ? ld_data : mem_wd;
  assign wb_wreg    = rst_n && (done ? mem_wreg && ld && !flush : mem_wreg && !mem);
  assign wb_exccode = !rst_n ? EXC_NONE :
                      (!done && misalign && mem_exccode == EXC_NONE) ? (st ? EXC_ADES : EXC_ADEL) :
                      mem_exccode;
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 mem_aluop  in  8  operation code from the EXE/MEM register; load/store codes come from the shared package.
REQ-005 mem_wa, mem_wreg, mem_mreg  in  5/1/1  writeback address, writeback enable, and load flag.
REQ-006 mem_wd  in  32  ALU result; this is the effective address for loads and stores.
REQ-007 mem_din  in  32  store data.
REQ-008 mem_exccode  in  5  upstream exception code; 5'h10 means no exception.
REQ-009 flush  in  1  pipeline flush.
REQ-010 dm_req, dm_we  out  1/1  data-memory request and write strobe.
REQ-011 dm_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-012 dm_be  out  4  byte enables.
REQ-013 dm_wdata  out  32  lane-replicated store data.
REQ-014 dm_ack  in  1  one-cycle completion pulse.
REQ-015 dm_rdata  in  32  read data, valid while dm_ack is high.
REQ-016 stall_req  out  1  stall request to pipeline control.
REQ-017 wb_wa, wb_wd, wb_wreg  out  5/32/1  writeback result to the MEM/WB register.
REQ-018 wb_exccode  out  5  resolved exception code.

Function
REQ-019 FSM states SHALL be IDLE, BUSY, DONE and DRAIN, with reset state IDLE.
REQ-020 An access SHALL be mem_aluop ∈ {LB, LBU, LH, LHU, LW, SB, SH, SW} with mem_exccode==5'h10 and no misalignment.
REQ-021 Misalignment SHALL be halfword addr[0]!=0 or word addr[1:0]!=0; wb_exccode SHALL be 5'h04 (load) or 5'h05 (store), no bus request SHALL issue, and wb_wreg SHALL be 0.
REQ-022 IDLE with an access and !flush SHALL register dm_req=1 plus addr/be/we/wdata, go to BUSY, and drive stall_req=1 combinationally in that same cycle.
REQ-023 BUSY SHALL hold all dm_* outputs stable and keep stall_req=1; on dm_ack it SHALL drop dm_req next edge, capture dm_rdata, and go to DONE.
REQ-024 DONE SHALL hold stall_req=0 for exactly one cycle, present the result on wb_*, then go to IDLE.
REQ-025 For a zero-wait memory, load-to-result latency SHALL be 3 cycles (IDLE→BUSY→DONE), with 1 cycle added per ack wait cycle.
REQ-026 Byte enables SHALL be 4'b0001<<addr[1:0] for SB, addr[1] ? 4'b1100 : 4'b0011 for SH, and 4'hF for SW.
REQ-027 dm_wdata SHALL be {4{din[7:0]}} for SB, {2{din[15:0]}} for SH, and din for SW.
REQ-028 Loads SHALL select the lane given by addr[1:0]; LB/LH sign-extend and LBU/LHU zero-extend.
REQ-029 Stores SHALL force wb_wreg=0.
REQ-030 Non-memory ops SHALL pass wa/wd/wreg/exccode through combinationally with stall_req=0.
REQ-031 Flush in IDLE SHALL issue no request.
REQ-032 Flush in BUSY SHALL NOT retract dm_req; the FSM SHALL go to DRAIN, keep stall_req=0, wait for dm_ack, discard the data, and return to IDLE.
REQ-033 Flush in DONE SHALL force wb_wreg=0.
REQ-034 dm_ack SHALL be ignored in IDLE and DONE.
REQ-035 Upstream inputs are held stable while stall_req=1; the block SHALL NOT re-sample them during BUSY.

Reset
REQ-036 rst_n low SHALL asynchronously force IDLE, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, and the captured read data to 0.
REQ-037 With reset asserted, combinational outputs SHALL read stall_req=0, wb_wreg=0 and wb_exccode=5'h10.
REQ-038 Reset mid-BUSY SHALL abandon the transaction, and a late dm_ack SHALL be ignored.

Structure
REQ-039 The aluop load/store codes, the exccode constants (5'h10, 5'h04, 5'h05) and the FSM state encoding SHALL live in the shared package mips32_defs.
REQ-040 Lane selection and extension SHALL be a combinational sub-module, load_align.

Verification
REQ-041 LW addr 32'h100 with ack on the 2nd BUSY cycle, rdata 32'hDEADBEEF SHALL give stall_req high for 3 cycles and then wb_wd=32'hDEADBEEF with wb_wreg=1.
REQ-042 SB addr 32'h203, din 32'h5A SHALL give dm_be=4'b1000, dm_wdata=32'h5A5A5A5A, dm_we=1 and wb_wreg=0.
REQ-043 LH addr 32'h102 with rdata 32'h8001_0000 SHALL give wb_wd=32'hFFFF8001; LHU with the same inputs SHALL give 32'h00008001.
REQ-044 LW addr 32'h101 SHALL give wb_exccode=5'h04, dm_req never high and stall_req=0; SH addr 32'h3 SHALL give 5'h05.
REQ-045 Flush in the 1st BUSY cycle with ack 2 cycles later SHALL keep dm_req high until ack, keep stall_req=0 from the flush, and produce no wb_wreg pulse.
REQ-046 rst_n low mid-BUSY followed by an ack after release SHALL return all outputs to reset values and issue no writeback.
